// File: rtl/config_reloj_pkg.sv
// Shared constants for the clock-setting front end: field codes, mode encoding,
// button indices and default timing.
package config_reloj_pkg;

    localparam logic [3:0] CAMPO_NINGUNO  = 4'd0;
    localparam logic [3:0] CAMPO_HORAS    = 4'd1;
    localparam logic [3:0] CAMPO_MINUTOS  = 4'd2;
    localparam logic [3:0] CAMPO_SEGUNDOS = 4'd3;
    localparam logic [3:0] CAMPO_DIA      = 4'd4;
    localparam logic [3:0] CAMPO_MES      = 4'd5;
    localparam logic [3:0] CAMPO_ANIO     = 4'd6;

    typedef enum logic {
        MODO_RUN    = 1'b0,
        MODO_CONFIG = 1'b1
    } modo_t;

    localparam int DEB_CICLOS_DEF  = 1_000_000;
    localparam int REP_INICIO_DEF  = 50_000_000;
    localparam int REP_PERIODO_DEF = 25_000_000;
    localparam int N_CAMPOS_DEF    = 6;

    localparam int BTN_CONFIG = 0;
    localparam int BTN_IZQ    = 1;
    localparam int BTN_DER    = 2;
    localparam int BTN_ARRIBA = 3;
    localparam int BTN_ABAJO  = 4;

    function automatic logic [3:0] campo_siguiente(input logic [3:0] campo, input int n);
        return (campo >= 4'(n)) ? CAMPO_HORAS : campo + 4'd1;
    endfunction

    function automatic logic [3:0] campo_anterior(input logic [3:0] campo, input int n);
        return (campo <= CAMPO_HORAS) ? 4'(n) : campo - 4'd1;
    endfunction

endpackage

// File: rtl/antirrebote.sv
// One push-button front end: 2-FF synchronizer, saturating debounce counter and
// a rising-edge press pulse that stays disarmed until a release is seen after reset.
module antirrebote
    import config_reloj_pkg::*;
#(
    parameter int DEB_CICLOS = DEB_CICLOS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic nivel,
    output logic pulso
);

    localparam int CW = $clog2(DEB_CICLOS + 1);

    logic [1:0]    sinc;
    logic [1:0]    sinc_ok;
    logic [CW-1:0] cuenta;
    logic          nivel_q;
    logic          armado;

    // sinc_ok marks when sinc[1] reflects the real pin rather than reset zeros,
    // so a button held through reset cannot arm itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sinc    <= '0;
            sinc_ok <= '0;
            cuenta  <= '0;
            nivel   <= 1'b0;
            nivel_q <= 1'b0;
            armado  <= 1'b0;
        end else begin
            sinc    <= {sinc[0], raw};
            sinc_ok <= {sinc_ok[0], 1'b1};
            nivel_q <= nivel;
            if (sinc[1] != nivel) begin
                if (cuenta >= CW'(DEB_CICLOS - 1)) begin
                    nivel  <= sinc[1];
                    cuenta <= '0;
                end else begin
                    cuenta <= cuenta + 1'b1;
                end
            end else begin
                cuenta <= '0;
            end
            if (sinc_ok[1] && !sinc[1] && !nivel) begin
                armado <= 1'b1;
            end
        end
    end

    assign pulso = armado & nivel & ~nivel_q;

endmodule

// File: rtl/control_configuracion.sv
// Mode/field selection and edit pulses for the clock-setting path.
// Optional auto-repeat of held up/down buttons: define CONTROL_CONFIG_AUTOREPEAT_EN.
module control_configuracion
    import config_reloj_pkg::*;
#(
    parameter int DEB_CICLOS  = DEB_CICLOS_DEF,
    parameter int REP_INICIO  = REP_INICIO_DEF,
    parameter int REP_PERIODO = REP_PERIODO_DEF,
    parameter int N_CAMPOS    = N_CAMPOS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_config,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    output logic [3:0] contadoresH,
    output logic       Arriba,
    output logic       Abajo,
    output logic       modo_config
);

    logic [4:0] botones;
    logic [4:0] nivel;
    logic [4:0] pulso;
    logic       ambos;
    logic       rep_arriba;
    logic       rep_abajo;
    modo_t      modo;

    assign botones = {btn_abajo, btn_arriba, btn_der, btn_izq, btn_config};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_antirrebote (
            .clk   (clk),
            .reset (reset),
            .raw   (botones[i]),
            .nivel (nivel[i]),
            .pulso (pulso[i])
        );
    end

    logic unused_niveles;
    assign unused_niveles = &{1'b0, nivel[BTN_DER:BTN_CONFIG]};

    assign ambos = nivel[BTN_ARRIBA] & nivel[BTN_ABAJO];

`ifdef CONTROL_CONFIG_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_INICIO > REP_PERIODO) ? REP_INICIO : REP_PERIODO;
    localparam int RW      = $clog2(REP_MAX + 1);

    logic [RW-1:0] rep_cuenta;
    logic [RW-1:0] rep_limite;
    logic          rep_activo;
    logic          rep_fase;
    logic          rep_dir_abajo;
    logic          rep_sostenido;
    logic          rep_disparo;

    assign rep_limite    = rep_fase ? RW'(REP_PERIODO - 1) : RW'(REP_INICIO - 1);
    assign rep_sostenido = rep_dir_abajo ? nivel[BTN_ABAJO] : nivel[BTN_ARRIBA];
    assign rep_disparo   = rep_activo && rep_sostenido && !ambos && (rep_cuenta == rep_limite);
    assign rep_arriba    = rep_disparo && !rep_dir_abajo;
    assign rep_abajo     = rep_disparo && rep_dir_abajo;

    // The press event itself loads 1, so the first repeat lands REP_INICIO
    // cycles after the event; later ones reload 0 and land every REP_PERIODO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cuenta    <= '0;
            rep_activo    <= 1'b0;
            rep_fase      <= 1'b0;
            rep_dir_abajo <= 1'b0;
        end else if (modo != MODO_CONFIG || pulso[BTN_CONFIG] || ambos) begin
            rep_cuenta <= '0;
            rep_activo <= 1'b0;
            rep_fase   <= 1'b0;
        end else if (pulso[BTN_ARRIBA] || pulso[BTN_ABAJO]) begin
            rep_cuenta    <= RW'(1);
            rep_activo    <= 1'b1;
            rep_fase      <= 1'b0;
            rep_dir_abajo <= pulso[BTN_ABAJO];
        end else if (!rep_activo || !rep_sostenido) begin
            rep_cuenta <= '0;
            rep_activo <= 1'b0;
            rep_fase   <= 1'b0;
        end else if (rep_cuenta == rep_limite) begin
            rep_cuenta <= '0;
            rep_fase   <= 1'b1;
        end else begin
            rep_cuenta <= rep_cuenta + 1'b1;
        end
    end
`else
    localparam int unused_rep = REP_INICIO + REP_PERIODO;
    assign rep_arriba = 1'b0;
    assign rep_abajo  = 1'b0;
`endif

    // Mode, field and edit pulses share one register stage, so a pulse always
    // leaves together with the field code it applies to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            modo        <= MODO_RUN;
            modo_config <= 1'b0;
            contadoresH <= CAMPO_NINGUNO;
            Arriba      <= 1'b0;
            Abajo       <= 1'b0;
        end else begin
            Arriba <= 1'b0;
            Abajo  <= 1'b0;
            case (modo)
                MODO_RUN: begin
                    if (pulso[BTN_CONFIG]) begin
                        modo        <= MODO_CONFIG;
                        modo_config <= 1'b1;
                        contadoresH <= CAMPO_HORAS;
                    end
                end
                MODO_CONFIG: begin
                    if (pulso[BTN_CONFIG]) begin
                        modo        <= MODO_RUN;
                        modo_config <= 1'b0;
                        contadoresH <= CAMPO_NINGUNO;
                    end else begin
                        if (pulso[BTN_DER] && !pulso[BTN_IZQ]) begin
                            contadoresH <= campo_siguiente(contadoresH, N_CAMPOS);
                        end else if (pulso[BTN_IZQ] && !pulso[BTN_DER]) begin
                            contadoresH <= campo_anterior(contadoresH, N_CAMPOS);
                        end
                        if (!ambos) begin
                            if (pulso[BTN_ARRIBA] || rep_arriba) begin
                                Arriba <= 1'b1;
                            end else if (pulso[BTN_ABAJO] || rep_abajo) begin
                                Abajo <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    modo        <= MODO_RUN;
                    modo_config <= 1'b0;
                    contadoresH <= CAMPO_NINGUNO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_configuracion.sv
// Bench for control_configuracion: directed and random button presses checked
// every cycle against a timeline model of mode, field and edit pulses.
module tb_control_configuracion;

    localparam int DEB = 4;
    localparam int INI = 20;
    localparam int PER = 8;
    localparam int N   = 6;
`ifdef CONTROL_CONFIG_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_config, btn_izq, btn_der, btn_arriba, btn_abajo;
    logic [3:0] contadoresH;
    logic       Arriba, Abajo, modo_config;

    int checks   = 0;
    int failures = 0;
    int m_modo   = 0;
    int m_campo  = 0;

    always #5 clk = ~clk;

    control_configuracion #(
        .DEB_CICLOS  (DEB),
        .REP_INICIO  (INI),
        .REP_PERIODO (PER),
        .N_CAMPOS    (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_config  (btn_config),
        .btn_izq     (btn_izq),
        .btn_der     (btn_der),
        .btn_arriba  (btn_arriba),
        .btn_abajo   (btn_abajo),
        .contadoresH (contadoresH),
        .Arriba      (Arriba),
        .Abajo       (Abajo),
        .modo_config (modo_config)
    );

    task automatic set_raw(input logic [4:0] m);
        btn_config = m[0];
        btn_izq    = m[1];
        btn_der    = m[2];
        btn_arriba = m[3];
        btn_abajo  = m[4];
    endtask

    task automatic checkOutput(input string tag, input int s, input logic e_arr,
                               input logic e_aba, input int e_modo, input int e_campo);
        logic [6:0] obs;
        logic [6:0] expv;
        obs  = {Arriba, Abajo, modo_config, contadoresH};
        expv = {e_arr, e_aba, e_modo[0], e_campo[3:0]};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s s=%0d observed Arriba=%b Abajo=%b modo=%b campo=%0d required Arriba=%b Abajo=%b modo=%b campo=%0d",
                   tag, s, obs[6], obs[5], obs[4], obs[3:0], expv[6], expv[5], expv[4], expv[3:0]);
        end
    endtask

    // Steady-state cycles: no pulses, model mode/field unchanged.
    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput(tag, -1, 1'b0, 1'b0, m_modo, m_campo);
        end
    endtask

    // Presses the buttons in mask (after optional bounce), holds each for its hold
    // length, and checks every cycle until all levels have settled released.
    task automatic applyStimulus(input string tag, input logic [4:0] mask, input int hold,
                                 input int hold_abajo, input int bounce, input int gap);
        int         h[5];
        int         t, last, s_end, hmax, n_modo, n_campo;
        bit         e_arr[0:255];
        bit         e_aba[0:255];
        logic [4:0] cur;
        for (int i = 0; i < 256; i++) begin
            e_arr[i] = 1'b0;
            e_aba[i] = 1'b0;
        end
        hmax = 0;
        for (int b = 0; b < 5; b++) begin
            h[b] = (b == 4) ? hold_abajo : hold;
            if (mask[b] && h[b] > hmax) hmax = h[b];
        end
        t       = 2 + DEB;
        s_end   = hmax + DEB + 4 + gap;
        n_modo  = m_modo;
        n_campo = m_campo;
        if (mask[0]) begin
            n_modo  = 1 - m_modo;
            n_campo = (n_modo == 1) ? 1 : 0;
        end else if (m_modo == 1) begin
            if (mask[2] && !mask[1]) n_campo = (m_campo % N) + 1;
            else if (mask[1] && !mask[2]) n_campo = (m_campo == 1) ? N : m_campo - 1;
            if (mask[3] != mask[4]) begin
                last = (mask[3] ? h[3] : h[4]) + 1 + DEB;
                if (mask[3]) e_arr[t + 1] = 1'b1; else e_aba[t + 1] = 1'b1;
                if (AUTOREP) begin
                    for (int p = t + INI; p - 1 <= last; p += PER) begin
                        if (mask[3]) e_arr[p] = 1'b1; else e_aba[p] = 1'b1;
                    end
                end
            end
        end
        for (int i = 0; i < bounce; i++) begin
            set_raw(mask);
            @(negedge clk);
            checkOutput({tag, "_bounce"}, -1, 1'b0, 1'b0, m_modo, m_campo);
            set_raw(5'b0);
            @(negedge clk);
            checkOutput({tag, "_bounce"}, -1, 1'b0, 1'b0, m_modo, m_campo);
        end
        cur = mask;
        set_raw(cur);
        for (int s = 1; s <= s_end; s++) begin
            @(negedge clk);
            checkOutput(tag, s, e_arr[s], e_aba[s], (s > t) ? n_modo : m_modo,
                        (s > t) ? n_campo : m_campo);
            for (int b = 0; b < 5; b++) begin
                if (cur[b] && s == h[b]) cur[b] = 1'b0;
            end
            set_raw(cur);
        end
        m_modo  = n_modo;
        m_campo = n_campo;
    endtask

    initial begin
        logic [4:0] mask;
        int         hold;
        reset = 1'b1;
        set_raw(5'b0);
        idle_check("reset_values", 2);
        reset = 1'b0;
        idle_check("after_reset", 3);

        applyStimulus("arriba_in_run", 5'b01000, 10, 10, 0, 0);
        applyStimulus("enter_config", 5'b00001, 8, 8, 0, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus("der_step", 5'b00100, 6 + i, 6 + i, i % 2, 1);
        end
        applyStimulus("izq_wrap", 5'b00010, 7, 7, 0, 0);
        applyStimulus("der_wrap_back", 5'b00100, 7, 7, 0, 0);
        applyStimulus("arriba_bounce", 5'b01000, 9, 9, 2, 0);
        applyStimulus("up_down_together", 5'b11000, 30, 15, 0, 2);
        applyStimulus("abajo_held", 5'b10000, 50, 50, 0, 0);
        applyStimulus("izq_der_together", 5'b00110, 8, 8, 0, 0);
        applyStimulus("config_wins", 5'b01001, 12, 12, 0, 0);
        applyStimulus("arriba_in_run2", 5'b01000, 30, 30, 1, 0);

        for (int i = 0; i < 30; i++) begin
            mask = 5'b0;
            mask[$urandom_range(0, 4)] = 1'b1;
            if ($urandom_range(0, 3) == 0) mask[$urandom_range(0, 4)] = 1'b1;
            hold = $urandom_range(DEB, 45);
            applyStimulus("random", mask, hold, hold, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        if (m_modo == 0) applyStimulus("pre_reset_config", 5'b00001, 6, 6, 0, 0);
        set_raw(5'b01001);
        idle_check("pre_reset_press", 3);
        reset   = 1'b1;
        m_modo  = 0;
        m_campo = 0;
        idle_check("reset_mid_press", 2);
        reset = 1'b0;
        idle_check("held_after_reset", 25);
        set_raw(5'b0);
        idle_check("release_after_reset", DEB + 6);
        applyStimulus("config_after_reset", 5'b00001, 8, 8, 0, 0);
        applyStimulus("arriba_after_reset", 5'b01000, 8, 8, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
